seg_display_mux: RTL and testbench
==================================

SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal 1..8.
REQ-002 SHALL have parameter SLOT_CYCLES, default 16, clock cycles per digit slot, legal value a multiple of 16, minimum 16.
REQ-003 SHALL have port fast_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port digits_in, input, 4*NUM_DIGITS bits; digit i at [4i+3:4i]; digit 0 is rightmost/least significant.
REQ-006 SHALL have port dp_in, input, NUM_DIGITS bits; bit i lights the decimal point of digit i.
REQ-007 SHALL have port blank_mask, input, NUM_DIGITS bits; bit i forces digit i dark.
REQ-008 SHALL have port blink_en, input, NUM_DIGITS bits; bit i makes digit i follow blink_phase.
REQ-009 SHALL have port blink_phase, input, 1 bit; while 1, digits with blink_en set are dark.
REQ-010 SHALL have port hex_mode, input, 1 bit; 0 = values 10..15 dark, 1 = glyphs A,b,C,d,E,F.
REQ-011 SHALL have port lz_suppress, input, 1 bit; enables leading-zero blanking.
REQ-012 SHALL have port brightness, input, 4 bits; on-time per slot, 15 = maximum.
REQ-013 SHALL have port segments, output, 8 bits, active-low {dp,g,f,e,d,c,b,a}, registered.
REQ-014 SHALL have port enables, output, NUM_DIGITS bits, active-low digit strobes, registered, at most one bit low at any time.
REQ-015 SHALL have port frame_tick, output, 1 bit, one-cycle pulse per completed scan frame, registered.

Function
REQ-016 SHALL keep a slot counter cnt (0..SLOT_CYCLES-1) and a digit index idx; cnt increments every cycle; on wrap, idx decrements, with idx 0 wrapping to NUM_DIGITS-1.
REQ-017 SHALL scan digits leftmost first: NUM_DIGITS-1 down to 0; frame length = NUM_DIGITS*SLOT_CYCLES cycles.
REQ-018 SHALL capture digits_in, dp_in, blank_mask, blink_en, blink_phase, hex_mode, lz_suppress and brightness into a snapshot at the clock edge ending state (idx=NUM_DIGITS-1, cnt=0); inputs SHALL have no effect on outputs at any other time.
REQ-019 SHALL, at the edge ending state (idx,cnt), register segments/enables for that state; latency is 1 cycle.
REQ-020 SHALL hold enables all-1 (dead time) for cnt=0 in every slot.
REQ-021 SHALL drive enables[idx]=0 iff cnt!=0, cnt < (brightness+1)*(SLOT_CYCLES/16), and digit idx is not dark.
REQ-022 SHALL treat digit i as dark if any of: blank_mask[i]; blink_en[i] and blink_phase; value>=10 and hex_mode=0; leading zero.
REQ-023 SHALL treat digit i as a leading zero iff lz_suppress=1, i!=0, and digit i plus all digits above i equal 0; digit 0 is never a leading zero.
REQ-024 SHALL drive segments[6:0] as follows; hex 0..9: C0,F9,A4,B0,99,92,82,F8,80,90; A..F: 88,83,C6,A1,86,8E (values given with dp bit set).
REQ-025 SHALL drive segments[7]=0 iff dp_in[idx]=1; a digit dark by any REQ-022 cause SHALL also suppress its dp.
REQ-026 SHALL drive segments=8'hFF whenever enables is all-1.
REQ-027 SHALL pulse frame_tick high for exactly the cycle after state (idx=0, cnt=SLOT_CYCLES-1).

Reset
REQ-028 SHALL, on rst=1 at a clock edge: set cnt=0, idx=NUM_DIGITS-1, segments=8'hFF, enables all-1, frame_tick=0, and clear the snapshot to 0.
REQ-029 SHALL let rst override all other activity, including mid-slot or mid-frame; the first cycle after release is state (NUM_DIGITS-1, 0), and a fresh snapshot is taken at its end.

Verification (NUM_DIGITS=4, SLOT_CYCLES=16)
REQ-030 SHALL cover: digits_in=16'h1234, brightness=15, all controls 0 -> per slot enables 0111,1011,1101,1110 low for 15 cycles each; segments F9,A4,B0,99; frame_tick every 64 cycles.
REQ-031 SHALL cover: digits_in=16'h0050, lz_suppress=1 -> digit3 and digit2 dark; digit1=92; digit0=C0.
REQ-032 SHALL cover: brightness=3 -> each enable low only for cnt 1..3, i.e. 3 cycles per 16-cycle slot.
REQ-033 SHALL cover: digits_in=16'hABCD, hex_mode=0 -> all dark; hex_mode=1 -> 88,83,C6,A1; dp_in=4'b0010 -> digit1 shows 8'h46.
REQ-034 SHALL cover: digits_in changed mid-frame -> outputs unchanged until the next frame; blink_en=4'b0001, blink_phase=1 -> digit0 dark.
REQ-035 SHALL cover: rst asserted mid-slot of digit 1 -> next cycle enables=4'b1111, segments=8'hFF; the scan restarts at digit 3.

Source files
------------

// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment driver: scans digits leftmost first from a
// per-frame input snapshot, with brightness PWM, blanking, blink and hex.
module seg_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 16
) (
  input  logic                    fast_clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    blink_phase,
  input  logic                    hex_mode,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [7:0]              segments,
  output logic [NUM_DIGITS-1:0]   enables,
  output logic                    frame_tick
);

  localparam int CW    = $clog2(SLOT_CYCLES);
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCALE = SLOT_CYCLES / 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   blen_q, blen_d;
  logic                    bph_q, bph_d;
  logic                    hex_q, hex_d;
  logic                    lz_q, lz_d;
  logic [3:0]              bri_q, bri_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    tick_q, tick_d;

  logic [NUM_DIGITS-1:0]   dark;
  logic                    zero_run;
  logic                    lead;
  logic [3:0]              cur_val;
  logic                    cur_dp;
  logic                    cur_dark;
  logic [31:0]             on_lim;
  logic                    lit;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
    endcase
    return g;
  endfunction

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    dig_d   = dig_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    blen_d  = blen_q;
    bph_d   = bph_q;
    hex_d   = hex_q;
    lz_d    = lz_q;
    bri_d   = bri_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == '0) ? IDX_TOP : idx_q - IW'(1);
    end
    // Snapshot is only taken while the dead-time slot of the top digit runs
    if (idx_q == IDX_TOP && cnt_q == '0) begin
      dig_d   = digits_in;
      dp_d    = dp_in;
      blank_d = blank_mask;
      blen_d  = blink_en;
      bph_d   = blink_phase;
      hex_d   = hex_mode;
      lz_d    = lz_suppress;
      bri_d   = brightness;
    end
  end

  always_comb begin
    dark     = '0;
    zero_run = 1'b1;
    lead     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (dig_q[4*i +: 4] == 4'd0);
      lead     = lz_q && (i != 0) && zero_run;
      dark[i]  = blank_q[i] || (blen_q[i] && bph_q) ||
                 (!hex_q && dig_q[4*i +: 4] >= 4'd10) || lead;
    end
  end

  always_comb begin
    cur_val  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_val  = dig_q[4*i +: 4];
        cur_dp   = dp_q[i];
        cur_dark = dark[i];
      end
    end
    on_lim = (32'(bri_q) + 32'd1) * 32'(SCALE);
    lit    = (cnt_q != '0) && (32'(cnt_q) < on_lim) && !cur_dark;
    seg_d  = 8'hFF;
    en_d   = '1;
    if (lit) begin
      seg_d = {~cur_dp, glyph(cur_val)};
      en_d  = ~(NUM_DIGITS'(1) << idx_q);
    end
    tick_d = (idx_q == '0) && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= IDX_TOP;
      dig_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      blen_q  <= '0;
      bph_q   <= 1'b0;
      hex_q   <= 1'b0;
      lz_q    <= 1'b0;
      bri_q   <= '0;
      seg_q   <= 8'hFF;
      en_q    <= '1;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      blen_q  <= blen_d;
      bph_q   <= bph_d;
      hex_q   <= hex_d;
      lz_q    <= lz_d;
      bri_q   <= bri_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
      tick_q  <= tick_d;
    end
  end

  assign segments   = seg_q;
  assign enables    = en_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: frame-level reference model of the scan,
// fed by directed settings and random inputs.
module tb_seg_display_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_en = '0;
  logic        blink_phase = 1'b0;
  logic        hex_mode = 1'b0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  brightness = '0;
  logic [7:0]  segments;
  logic [3:0]  enables;
  logic        frame_tick;

  seg_display_mux #(.NUM_DIGITS(4), .SLOT_CYCLES(16)) dut (
    .fast_clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
    .blank_mask(blank_mask), .blink_en(blink_en),
    .blink_phase(blink_phase), .hex_mode(hex_mode),
    .lz_suppress(lz_suppress), .brightness(brightness),
    .segments(segments), .enables(enables), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n = 0;
  logic [12:0] exp_v;

  logic [15:0] s_dig;
  logic [3:0]  s_dp, s_blank, s_blen, s_bri;
  logic        s_bph, s_hex, s_lz;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4;
      4'h3: return 8'hB0; 4'h4: return 8'h99; 4'h5: return 8'h92;
      4'h6: return 8'h82; 4'h7: return 8'hF8; 4'h8: return 8'h80;
      4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  // Expected {segments, enables, frame_tick} after the cycle k of the scan
  function automatic logic [12:0] model(input int k);
    int d, c;
    logic [3:0] v;
    logic [15:0] above;
    logic dk, lit;
    logic [7:0] s;
    logic [3:0] e;
    d = 3 - (k / 16) % 4;
    c = k % 16;
    v = s_dig[4*d +: 4];
    above = s_dig >> (4 * d);
    dk = s_blank[d] || (s_blen[d] && s_bph) || (v >= 4'd10 && !s_hex) ||
         (s_lz && d != 0 && above == 16'd0);
    lit = (c != 0) && (c < int'(s_bri) + 1) && !dk;
    s = 8'hFF;
    e = 4'hF;
    if (lit) begin
      s = {~s_dp[d], glyph(v)[6:0]};
      e = 4'hF & ~(4'b0001 << d);
    end
    return {s, e, (k % 64 == 63)};
  endfunction

  task automatic clear_snap();
    s_dig = '0; s_dp = '0; s_blank = '0; s_blen = '0;
    s_bri = '0; s_bph = 1'b0; s_hex = 1'b0; s_lz = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    if (n % 64 == 0) begin
      s_dig = digits_in; s_dp = dp_in; s_blank = blank_mask;
      s_blen = blink_en; s_bph = blink_phase; s_hex = hex_mode;
      s_lz = lz_suppress; s_bri = brightness;
    end
    #1;
    exp_v = model(n);
    n++;
  endtask

  task automatic set_inputs(input logic [15:0] dg, input logic [3:0] dp,
                            input logic [3:0] bl, input logic [3:0] be,
                            input logic ph, input logic hx, input logic lz,
                            input logic [3:0] br);
    digits_in = dg; dp_in = dp; blank_mask = bl; blink_en = be;
    blink_phase = ph; hex_mode = hx; lz_suppress = lz; brightness = br;
  endtask

  task automatic rand_inputs();
    set_inputs(16'($urandom), 4'($urandom), 4'($urandom & $urandom),
               4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               4'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({segments, enables, frame_tick} !== {8'hFF, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL reset got seg=%h en=%b tick=%b want seg=ff en=1111 tick=0",
               segments, enables, frame_tick);
    end
    rst = 1'b0;
    n = 0;
    clear_snap();
  endtask

  task automatic run_checked(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      checks++;
      if ({segments, enables, frame_tick} !== exp_v) begin
        errors++;
        $display("FAIL %s n=%0d got seg=%h en=%b tick=%b want seg=%h en=%b tick=%b",
                 name, n - 1, segments, enables, frame_tick,
                 exp_v[12:5], exp_v[4:1], exp_v[0]);
      end
    end
  endtask

  task automatic test_basic();
    set_inputs(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd15);
    run_checked("basic", 192);
  endtask

  task automatic test_lz();
    set_inputs(16'h0050, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd15);
    run_checked("lz", 128);
    set_inputs(16'h0000, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd15);
    run_checked("lz_zero", 128);
  endtask

  task automatic test_brightness();
    set_inputs(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd3);
    run_checked("bright3", 128);
    set_inputs(16'h8888, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    run_checked("bright0", 128);
  endtask

  task automatic test_hex();
    set_inputs(16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd15);
    run_checked("hex_off", 128);
    set_inputs(16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd15);
    run_checked("hex_on", 128);
    set_inputs(16'hABCD, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd15);
    run_checked("hex_dp", 128);
  endtask

  task automatic test_blink();
    set_inputs(16'h1234, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd15);
    run_checked("blink", 128);
    set_inputs(16'h5678, 4'hF, 4'b0100, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd15);
    run_checked("blank", 128);
  endtask

  task automatic test_snapshot();
    for (int i = 0; i < 320; i++) begin
      run_checked("snapshot", 1);
      rand_inputs();
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++) begin
      rand_inputs();
      run_checked("rand_frame", 64);
    end
  endtask

  task automatic test_reset_mid();
    set_inputs(16'h4321, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd15);
    run_checked("pre_reset", 64);
    while (n % 64 != 37) run_checked("pre_reset", 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({segments, enables, frame_tick} !== {8'hFF, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got seg=%h en=%b tick=%b want seg=ff en=1111 tick=0",
               segments, enables, frame_tick);
    end
    rst = 1'b0;
    n = 0;
    clear_snap();
    run_checked("post_reset", 128);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_brightness();
    test_hex();
    test_blink();
    test_snapshot();
    test_random_frames();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
